looper_mem_arb: RTL

LOOPER_MEM_ARB -- requirements
Module: looper_mem_arb

---
 rtl/looper_mem_arb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/looper_mem_arb.sv
// Two-requester arbiter for an asynchronous SRAM: record (write) and playback (read)
// share the RAM through fixed-length strobe windows with round-robin tie-breaking.
module looper_mem_arb #(
  parameter int ACC_CYCLES = 26,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk_100MHz,
  input  logic        rstn,
  input  logic        wr_req,
  input  logic [26:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  input  logic        rd_req,
  input  logic [26:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_done,
  output logic [26:0] ram_a,
  output logic [31:0] ram_dq_i,
  input  logic [31:0] ram_dq_o,
  output logic        RamCEn,
  output logic        RamOEn,
  output logic        RamWEn,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [7:0] ACC_LOAD = 8'(ACC_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        last_wr_q, last_wr_d;
  logic [26:0] ram_a_q, ram_a_d;
  logic [31:0] ram_dq_i_q, ram_dq_i_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        wr_done_q, wr_done_d;
  logic        rd_done_q, rd_done_d;
  logic        busy_q, busy_d;

  // Next-state, grant and strobe computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    last_wr_d  = last_wr_q;
    ram_a_d    = ram_a_q;
    ram_dq_i_d = ram_dq_i_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    rd_data_d  = rd_data_q;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // rd wins a tie only when wr took the previous grant
        if (rd_req && (!wr_req || last_wr_q)) begin
          state_d   = ACCESS;
          cnt_d     = ACC_LOAD;
          is_wr_d   = 1'b0;
          last_wr_d = 1'b0;
          ram_a_d   = rd_addr;
          ce_n_d    = 1'b0;
          oe_n_d    = 1'b0;
          we_n_d    = 1'b1;
        end else if (wr_req) begin
          state_d    = ACCESS;
          cnt_d      = ACC_LOAD;
          is_wr_d    = 1'b1;
          last_wr_d  = 1'b1;
          ram_a_d    = wr_addr;
          ram_dq_i_d = wr_data;
          ce_n_d     = 1'b0;
          oe_n_d     = 1'b1;
          we_n_d     = 1'b0;
        end else begin
          ce_n_d = 1'b1;
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          state_d = RECOVER;
          cnt_d   = GAP_LOAD;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (is_wr_q) begin
            wr_done_d = 1'b1;
          end else begin
            rd_done_d = 1'b1;
            rd_data_d = ram_dq_o;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset raises strobes without waiting for a clock
  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      is_wr_q    <= 1'b0;
      last_wr_q  <= 1'b1;
      ram_a_q    <= 27'd0;
      ram_dq_i_q <= 32'd0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rd_data_q  <= 32'd0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      last_wr_q  <= last_wr_d;
      ram_a_q    <= ram_a_d;
      ram_dq_i_q <= ram_dq_i_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rd_data_q  <= rd_data_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      busy_q     <= busy_d;
    end
  end

  assign ram_a    = ram_a_q;
  assign ram_dq_i = ram_dq_i_q;
  assign RamCEn   = ce_n_q;
  assign RamOEn   = oe_n_q;
  assign RamWEn   = we_n_q;
  assign rd_data  = rd_data_q;
  assign wr_done  = wr_done_q;
  assign rd_done  = rd_done_q;
  assign busy     = busy_q;

endmodule
